// File: rtl/uart_stop_check_seq.sv
// -----------------------------------------------------------------------------
// uart_stop_check_seq
//
// Registered stop-bit checker for the UART receive path. It sits between the
// data-bit shift stage and the RX data register. It captures the assembled
// word when the stop phase begins and samples STOP_BITS stop bits on the
// mid-bit strobe. It then publishes the word with a one-cycle valid pulse, or
// publishes zero with a framing error. It also keeps a saturating
// framing-error counter, flags break frames and pulses overrun when a new
// frame arrives while the checker is still busy.
//
// Optional feature: define STOP_CHECK_PARITY_EN to latch parity_in and report
// an even-parity mismatch on parity_error. Without the macro, parity_in is
// ignored and parity_error is tied low.
//
// Parameters
//   DATA_W     data word width (5..9)
//   STOP_BITS  stop bits sampled per frame (1..4)
//   CNT_W      width of the saturating framing-error counter
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   sample_tick   one-cycle mid-bit sample strobe
//   rx_in         synchronised serial RX line
//   check_stop    one-cycle pulse: data bits complete, data_in/parity_in valid
//   data_in       assembled data word
//   parity_in     received parity bit
//   err_clr       clears error_count (wins over a same-cycle increment)
//   data_out      checked word, zero on a framing error
//   data_valid    one-cycle pulse: published outputs updated
//   stop_error    framing error for the last published frame
//   break_det     last frame was a break (zero data, stop bit low)
//   parity_error  parity mismatch for the last published frame
//   overrun       one-cycle pulse: check_stop arrived while busy
//   error_count   saturating count of frames with stop_error
//   busy          high while the stop bits are being sampled
// -----------------------------------------------------------------------------
module uart_stop_check_seq #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              rx_in,
  input  logic              check_stop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              parity_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              stop_error,
  output logic              break_det,
  output logic              parity_error,
  output logic              overrun,
  output logic [CNT_W-1:0]  error_count,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  // Counter value on the tick that samples the last stop bit.
  localparam logic [1:0]       LAST_CNT = 2'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_r;
  logic [DATA_W-1:0] shadow_r;
  logic [1:0]        bit_cnt_r;
  logic              err_acc_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic              stop_error_r;
  logic              break_det_r;
  logic              overrun_r;
  logic [CNT_W-1:0]  error_count_r;

  logic              final_tick_s;
  logic              final_err_s;

  // The final tick also folds in the current rx_in sample.
  assign final_tick_s = (state_r == ST_STOP) && sample_tick && (bit_cnt_r == LAST_CNT);
  assign final_err_s  = err_acc_r | ~rx_in;

  // Frame FSM: capture on check_stop, sample stop bits, publish on final tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shadow_r     <= {DATA_W{1'b0}};
      bit_cnt_r    <= 2'd0;
      err_acc_r    <= 1'b0;
      data_out_r   <= {DATA_W{1'b0}};
      data_valid_r <= 1'b0;
      stop_error_r <= 1'b0;
      break_det_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A tick in the capture cycle is deliberately not sampled.
          if (check_stop) begin
            shadow_r  <= data_in;
            bit_cnt_r <= 2'd0;
            err_acc_r <= 1'b0;
            state_r   <= ST_STOP;
          end
        end
        ST_STOP: begin
          // A new frame while sampling is dropped; the shadow word is kept.
          overrun_r <= check_stop;
          if (sample_tick) begin
            err_acc_r <= final_err_s;
            bit_cnt_r <= bit_cnt_r + 2'd1;
            if (bit_cnt_r == LAST_CNT) begin
              data_out_r   <= final_err_s ? {DATA_W{1'b0}} : shadow_r;
              stop_error_r <= final_err_s;
              break_det_r  <= final_err_s & (shadow_r == {DATA_W{1'b0}});
              data_valid_r <= 1'b1;
              state_r      <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating framing-error counter; a clear overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      error_count_r <= {CNT_W{1'b0}};
    end else if (err_clr) begin
      error_count_r <= {CNT_W{1'b0}};
    end else if (final_tick_s && final_err_s && (error_count_r != CNT_MAX)) begin
      error_count_r <= error_count_r + CNT_W'(1'b1);
    end
  end

`ifdef STOP_CHECK_PARITY_EN
  logic parity_latch_r;
  logic parity_error_r;

  // Even parity over word and parity bit: a set result is a mismatch.
  function automatic logic even_parity_err(input logic [DATA_W-1:0] word,
                                           input logic              par);
    return ^{word, par};
  endfunction

  // Parity latch follows the shadow capture; the result is published with the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_latch_r <= 1'b0;
      parity_error_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && check_stop) begin
        parity_latch_r <= parity_in;
      end
      if (final_tick_s) begin
        parity_error_r <= even_parity_err(shadow_r, parity_latch_r);
      end
    end
  end

  assign parity_error = parity_error_r;
`else
  logic parity_in_unused_s;
  assign parity_in_unused_s = parity_in;
  assign parity_error       = 1'b0;
`endif

  assign data_out    = data_out_r;
  assign data_valid  = data_valid_r;
  assign stop_error  = stop_error_r;
  assign break_det   = break_det_r;
  assign overrun     = overrun_r;
  assign error_count = error_count_r;
  assign busy        = (state_r == ST_STOP);

endmodule

// File: tb/tb_uart_stop_check_seq.sv
// -----------------------------------------------------------------------------
// tb_uart_stop_check_seq
//
// Two instances share one stimulus stream:
//   dut0: STOP_BITS=1, CNT_W=2
//   dut1: STOP_BITS=2, CNT_W=8
// A frame-level model predicts every output of both instances, and all outputs
// are compared on each falling edge. Directed literal checks pin the model to
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_stop_check_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic       check_stop = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       parity_in = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b, serr_a, serr_b, brk_a, brk_b;
  logic       perr_a, perr_b, ovr_a, ovr_b, busy_a, busy_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;

  int checks = 0;
  int errors = 0;

`ifdef STOP_CHECK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  initial forever #5 clk = ~clk;

  uart_stop_check_seq #(.DATA_W(8), .STOP_BITS(1), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_in(rx_in),
    .check_stop(check_stop), .data_in(data_in), .parity_in(parity_in),
    .err_clr(err_clr), .data_out(dout_a), .data_valid(dv_a),
    .stop_error(serr_a), .break_det(brk_a), .parity_error(perr_a),
    .overrun(ovr_a), .error_count(cnt_a), .busy(busy_a)
  );

  uart_stop_check_seq #(.DATA_W(8), .STOP_BITS(2), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .rx_in(rx_in),
    .check_stop(check_stop), .data_in(data_in), .parity_in(parity_in),
    .err_clr(err_clr), .data_out(dout_b), .data_valid(dv_b),
    .stop_error(serr_b), .break_det(brk_b), .parity_error(perr_b),
    .overrun(ovr_b), .error_count(cnt_b), .busy(busy_b)
  );

  // ---------------- frame-level model ----------------
  int         sb   [2] = '{1, 2};
  int         cmax [2] = '{3, 255};
  bit         m_busy [2];
  logic [7:0] m_word [2];
  bit         m_par  [2];
  int         m_samp [2];
  bit         m_bad  [2];
  logic [7:0] e_data [2];
  bit         e_dv [2], e_err [2], e_brk [2], e_perr [2], e_ovr [2];
  int         e_cnt [2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit fin;
      fin = 1'b0;
      if (!rst_n) begin
        m_busy[k] = 1'b0; m_samp[k] = 0; m_bad[k] = 1'b0;
        m_word[k] = 8'h00; m_par[k] = 1'b0;
        e_data[k] = 8'h00; e_dv[k] = 1'b0; e_err[k] = 1'b0;
        e_brk[k] = 1'b0; e_perr[k] = 1'b0; e_ovr[k] = 1'b0; e_cnt[k] = 0;
      end else begin
        e_dv[k]  = 1'b0;
        e_ovr[k] = 1'b0;
        if (m_busy[k]) begin
          if (check_stop) e_ovr[k] = 1'b1;
          if (sample_tick) begin
            m_samp[k]++;
            if (rx_in == 1'b0) m_bad[k] = 1'b1;
            if (m_samp[k] == sb[k]) fin = 1'b1;
          end
        end else if (check_stop) begin
          m_busy[k] = 1'b1; m_word[k] = data_in; m_par[k] = parity_in;
          m_samp[k] = 0; m_bad[k] = 1'b0;
        end
        if (fin) begin
          m_busy[k] = 1'b0;
          e_dv[k]   = 1'b1;
          e_err[k]  = m_bad[k];
          e_data[k] = m_bad[k] ? 8'h00 : m_word[k];
          e_brk[k]  = m_bad[k] && (m_word[k] == 8'h00);
          e_perr[k] = PAR_EN ? (^{m_word[k], m_par[k]}) : 1'b0;
        end
        if (err_clr) e_cnt[k] = 0;
        else if (fin && m_bad[k] && e_cnt[k] < cmax[k]) e_cnt[k]++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int k, input logic [7:0] d, input logic dv,
                         input logic se, input logic bk, input logic pe,
                         input logic ov, input logic bz, input logic [7:0] c);
    chk("data_out", k, 32'(d), 32'(e_data[k]));
    chk("data_valid", k, 32'(dv), 32'(e_dv[k]));
    chk("stop_error", k, 32'(se), 32'(e_err[k]));
    chk("break_det", k, 32'(bk), 32'(e_brk[k]));
    chk("parity_error", k, 32'(pe), 32'(e_perr[k]));
    chk("overrun", k, 32'(ov), 32'(e_ovr[k]));
    chk("busy", k, 32'(bz), 32'(m_busy[k]));
    chk("error_count", k, 32'(c), 32'(e_cnt[k]));
  endtask

  // Compare process: every falling edge, both instances against the model.
  initial forever begin
    @(negedge clk);
    cmp_dut(0, dout_a, dv_a, serr_a, brk_a, perr_a, ovr_a, busy_a, {6'd0, cnt_a});
    cmp_dut(1, dout_b, dv_b, serr_b, brk_b, perr_b, ovr_b, busy_b, cnt_b);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic cs, input logic [7:0] d, input logic p,
                     input logic tk, input logic rx, input logic clr);
    check_stop = cs; data_in = d; parity_in = p;
    sample_tick = tk; rx_in = rx; err_clr = clr;
    @(negedge clk);
  endtask

  task automatic start(input logic [7:0] d, input logic p);
    cyc(1'b1, d, p, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic tick(input logic rx, input logic clr);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, rx, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    idle(2);
    chk("reset_valid", 0, 32'(dv_a), 32'd0);
    chk("reset_count", 0, 32'(cnt_a), 32'd0);
    chk("reset_data", 1, 32'(dout_b), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Good frame A5.
    start(8'hA5, 1'b0);
    chk("t1_busy", 0, 32'(busy_a), 32'd1);
    tick(1'b1, 1'b0);
    chk("t1_valid", 0, 32'(dv_a), 32'd1);
    chk("t1_data", 0, 32'(dout_a), 32'hA5);
    chk("t1_stop_error", 0, 32'(serr_a), 32'd0);
    chk("t1_count", 0, 32'(cnt_a), 32'd0);
    chk("t1_b_waiting", 1, 32'(busy_b), 32'd1);
    tick(1'b1, 1'b0);
    chk("t1_b_data", 1, 32'(dout_b), 32'hA5);
    idle(1);
    chk("t1_hold_valid", 0, 32'(dv_a), 32'd0);
    chk("t1_hold_data", 0, 32'(dout_a), 32'hA5);

    // Second stop bit low on the two-stop-bit instance.
    start(8'h3C, 1'b0);
    tick(1'b1, 1'b0);
    chk("t2_a_data", 0, 32'(dout_a), 32'h3C);
    tick(1'b0, 1'b0);
    chk("t2_data", 1, 32'(dout_b), 32'h00);
    chk("t2_stop_error", 1, 32'(serr_b), 32'd1);
    chk("t2_break", 1, 32'(brk_b), 32'd0);
    chk("t2_count", 1, 32'(cnt_b), 32'd1);

    // Break frame.
    start(8'h00, 1'b0);
    tick(1'b0, 1'b0);
    chk("t3_break", 0, 32'(brk_a), 32'd1);
    chk("t3_stop_error", 0, 32'(serr_a), 32'd1);
    tick(1'b0, 1'b0);
    chk("t3_break", 1, 32'(brk_b), 32'd1);
    chk("t3_count", 1, 32'(cnt_b), 32'd2);

    // Overrun: second check_stop while busy, original word survives.
    start(8'h5A, 1'b0);
    start(8'hFF, 1'b0);
    chk("t4_overrun", 0, 32'(ovr_a), 32'd1);
    chk("t4_overrun", 1, 32'(ovr_b), 32'd1);
    idle(1);
    chk("t4_overrun_pulse", 0, 32'(ovr_a), 32'd0);
    idle(2);
    tick(1'b1, 1'b0);
    chk("t4_data", 0, 32'(dout_a), 32'h5A);
    tick(1'b1, 1'b0);
    chk("t4_data", 1, 32'(dout_b), 32'h5A);

    // Counter saturation and clear-wins.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_clear", 0, 32'(cnt_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      start(8'h11, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
    end
    chk("t5_saturate", 0, 32'(cnt_a), 32'd3);
    chk("t5_count", 1, 32'(cnt_b), 32'd4);
    start(8'h11, 1'b0);
    tick(1'b0, 1'b1);
    chk("t5_clear_wins", 0, 32'(cnt_a), 32'd0);
    chk("t5_clear_wins_err", 0, 32'(serr_a), 32'd1);
    tick(1'b0, 1'b0);
    chk("t5_after_clear", 1, 32'(cnt_b), 32'd1);

    // Parity: 01 with parity bit 0 is an even-parity mismatch.
    start(8'h01, 1'b0);
    tick(1'b1, 1'b0);
    chk("t6_data", 0, 32'(dout_a), 32'h01);
    chk("t6_parity", 0, 32'(perr_a), 32'(PAR_EN));
    tick(1'b1, 1'b0);
    chk("t6_parity", 1, 32'(perr_b), 32'(PAR_EN));

    // check_stop in the data_valid cycle is accepted.
    start(8'hC3, 1'b0);
    tick(1'b1, 1'b0);
    start(8'h96, 1'b0);
    chk("t7_accept", 0, 32'(busy_a), 32'd1);
    chk("t7_overrun", 1, 32'(ovr_b), 32'd1);
    tick(1'b1, 1'b0);
    chk("t7_data", 0, 32'(dout_a), 32'h96);
    chk("t7_data", 1, 32'(dout_b), 32'hC3);

    // Reset mid-frame aborts without a valid pulse.
    start(8'h77, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("t8_busy", 0, 32'(busy_a), 32'd0);
    tick(1'b0, 1'b0);
    chk("t8_no_valid", 0, 32'(dv_a), 32'd0);
    tick(1'b0, 1'b0);
    chk("t8_no_valid", 1, 32'(dv_b), 32'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_stop_check_seq.md
Name: uart_stop_check_seq

Overview:
- Registered, parametrised stop-bit checker for the UART receiver path.
- Sits after the data-bit shift stage and before the RX data register.
- Captures the assembled data word when the stop phase begins, samples 1 to 4 stop bits on the receiver's mid-bit sample strobe, then publishes the word with a one-cycle valid pulse, or zero plus an error.
- Adds a saturating framing-error counter, break detection and overrun flagging.

Parameters:
DATA_W, 8, data word width (5 to 9)
STOP_BITS, 1, number of stop bits sampled per frame (1 to 4)
CNT_W, 8, width of the saturating framing-error counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
sample_tick  input  1  one-cycle mid-bit sample strobe from the baud generator
rx_in  input  1  synchronised serial RX line
check_stop  input  1  one-cycle pulse from the shift stage: the data bits are complete
data_in  input  DATA_W  assembled data word, valid in the check_stop cycle
parity_in  input  1  received parity bit, valid in the check_stop cycle
err_clr  input  1  clears error_count
data_out  output  DATA_W  checked word; zero on a framing error
data_valid  output  1  one-cycle pulse: data_out, stop_error and break_det updated
stop_error  output  1  framing error for the last published frame
break_det  output  1  last frame was a break: data zero and stop bit low
parity_error  output  1  parity mismatch for the last published frame
overrun  output  1  one-cycle pulse: check_stop arrived while busy
error_count  output  CNT_W  saturating count of frames with stop_error
busy  output  1  high while in the STOP state

Behaviour:
- Reset, applied when rst_n is low at a clk edge:
  - state = IDLE;
  - all outputs = 0;
  - shadow word, parity latch, bit counter and error accumulator = 0.
- State IDLE:
  - check_stop = 1 → latch data_in into the shadow register and parity_in into the parity latch, clear the bit counter and error accumulator, go to STOP.
  - A sample_tick in the same cycle as check_stop is ignored.
- State STOP, on each sample_tick:
  - err_acc |= ~rx_in;
  - bit counter increments.
- The tick on which the counter equals STOP_BITS-1 is the final tick. On that edge:
  - compute final_err = err_acc | ~rx_in;
  - data_out = final_err ? 0 : shadow;
  - stop_error = final_err;
  - break_det = final_err & (shadow == 0);
  - data_valid = 1;
  - go to IDLE.
- Latency: data_valid is high exactly in the cycle after the final sample_tick.
- data_out, stop_error, break_det and parity_error hold their values until the next data_valid.
- Cycles without sample_tick in STOP: state holds. There is no timeout.
- check_stop while in STOP:
  - ignored; the shadow register is unchanged;
  - overrun pulses high for one cycle.
- check_stop in the data_valid cycle (state is already IDLE): accepted normally.
- error_count:
  - +1 on each data_valid with stop_error = 1;
  - saturates at 2^CNT_W-1;
  - err_clr = 1 sets it to 0;
  - err_clr and an increment in the same cycle → 0 (clear wins).
- Reset mid-frame: aborts the frame. No data_valid is issued and error_count becomes 0.
- STOP_BITS = 1: the first tick in STOP is the final tick.

Optional Feature:
- Macro STOP_CHECK_PARITY_EN.
- Defined:
  - on the final tick, parity_error = ^{shadow, parity_latch} (even parity; a mismatch gives 1);
  - a parity error does not zero data_out and does not count in error_count.
- Undefined:
  - parity_in is ignored;
  - parity_error is constant 0;
  - no parity latch is synthesised.

Test Plan:
- Reset, STOP_BITS=1: check_stop with data_in=8'hA5, then one tick with rx_in=1 → next cycle data_valid=1, data_out=8'hA5, stop_error=0, error_count=0.
- STOP_BITS=2: data_in=8'h3C, first tick rx_in=1, second tick rx_in=0 → data_out=0, stop_error=1, break_det=0, error_count=1.
- Break frame: data_in=8'h00, stop tick rx_in=0 → stop_error=1, break_det=1.
- Second check_stop while busy=1, data_in=8'hFF → overrun pulses one cycle; the frame later publishes the original word 8'h5A.
- CNT_W=2: four framing-error frames → error_count stays at 3. err_clr asserted in the same cycle as a fifth error → error_count=0.
- STOP_CHECK_PARITY_EN defined: data_in=8'h01, parity_in=0 → parity_error=1, data_out=8'h01. Same test with the macro undefined → parity_error=0.
